// File: rtl/img_pkg.sv
// Shared image-pipeline constants: raster geometry, Sobel row pitch, luma weights
// and the gray_pad state encoding.
package img_pkg;

  localparam int unsigned IMG_W = 480;
  localparam int unsigned IMG_H = 480;
  localparam int unsigned PAD_W = IMG_W + 2;

  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    LEFT,
    ACTIVE,
    RIGHT,
    BOTTOM
  } gp_state_e;

endpackage

// File: rtl/rgb_luma.sv
// Combinational RGB888 -> 8-bit luma, Y = (77R + 150G + 29B) >> 8, truncated.
module rgb_luma
  import img_pkg::*;
(
  input  logic [23:0] rgb,
  output logic [7:0]  y
);

  logic [15:0] acc;

  // Weights sum to 256, so the 16-bit sum tops out at 65280 and cannot wrap.
  always_comb begin
    acc = 16'(LUMA_R) * 16'(rgb[23:16])
        + 16'(LUMA_G) * 16'(rgb[15:8])
        + 16'(LUMA_B) * 16'(rgb[7:0]);
    y   = 8'(acc >> 8);
  end

endmodule

// File: rtl/gray_pad.sv
// Converts an RGB raster to luma and wraps it in a one-pixel zero border,
// producing a PAD_W-pitch grayscale stream for the Sobel stage.
module gray_pad #(
  parameter int unsigned IMG_W = img_pkg::IMG_W,
  parameter int unsigned IMG_H = img_pkg::IMG_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] in_rgb,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sol,
  output logic        out_sof,
  output logic        busy,
  output logic        done
);

  import img_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_W + 2);
  localparam int unsigned ROW_W = $clog2(IMG_H + 2);

  gp_state_e        state, state_nx;
  logic [COL_W-1:0] col, col_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic             emit;
  logic             last;
  logic [7:0]       pix;
  logic [7:0]       luma;

  rgb_luma u_luma (
    .rgb (in_rgb),
    .y   (luma)
  );

  assign in_ready = (state == ACTIVE);
  assign busy     = (state != IDLE);

  // Next state, raster position and the pixel to emit this cycle.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    emit     = 1'b0;
    last     = 1'b0;
    pix      = 8'd0;
    case (state)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished frame.
        if (start && !done) begin
          state_nx = TOP;
          col_nx   = '0;
          row_nx   = '0;
        end
      end
      TOP: begin
        emit = 1'b1;
        if (col == COL_W'(IMG_W + 1)) begin
          state_nx = LEFT;
          col_nx   = '0;
          row_nx   = ROW_W'(1);
        end else begin
          col_nx = col + COL_W'(1);
        end
      end
      LEFT: begin
        emit     = 1'b1;
        col_nx   = COL_W'(1);
        state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (in_valid) begin
          emit   = 1'b1;
          pix    = luma;
          col_nx = col + COL_W'(1);
          if (col == COL_W'(IMG_W)) state_nx = RIGHT;
        end
      end
      RIGHT: begin
        emit     = 1'b1;
        col_nx   = '0;
        row_nx   = row + ROW_W'(1);
        state_nx = (row < ROW_W'(IMG_H)) ? LEFT : BOTTOM;
      end
      BOTTOM: begin
        emit = 1'b1;
        if (col == COL_W'(IMG_W + 1)) begin
          state_nx = IDLE;
          col_nx   = '0;
          last     = 1'b1;
        end else begin
          col_nx = col + COL_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_sof   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      out_data  <= pix;
      out_valid <= emit;
      out_sol   <= emit && (col == '0);
      out_sof   <= emit && (col == '0) && (row == '0);
      done      <= last;
    end
  end

endmodule

// File: tb/tb_gray_pad.sv
// Directed bench for gray_pad on a 4x2 raster: padding, luma, handshake bubbles,
// reset abort and start filtering.
module tb_gray_pad;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned PW = W + 2;
  localparam int unsigned N  = PW * (H + 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] in_rgb;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sol;
  logic        out_sof;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  gray_pad #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_rgb    (in_rgb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sol   (out_sol),
    .out_sof   (out_sof),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] vec   [8];
  int          exp_y [8];

  int   cap_n, bubbles, xfers, rdy_cycles, done_cnt;
  logic [7:0] cap_d    [64];
  logic       cap_sol  [64];
  logic       cap_sof  [64];
  logic       cap_done [64];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one frame. vmode 0: in_valid held high, 1: toggles each cycle.
  // rst_at > 0 asserts rst right after that many outputs have been seen.
  // restart re-pulses start mid-frame and in the done cycle.
  task automatic run_frame(input int vmode, input int rst_at, input bit restart,
                           output bit saw_done);
    int idx;
    idx = 0;
    cap_n = 0; bubbles = 0; xfers = 0; rdy_cycles = 0; done_cnt = 0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !saw_done; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (cap_n < 64) begin
          cap_d[cap_n]    = out_data;
          cap_sol[cap_n]  = out_sol;
          cap_sof[cap_n]  = out_sof;
          cap_done[cap_n] = done;
        end
        cap_n++;
      end else if (cap_n > 0) begin
        bubbles++;
      end
      if (done) begin
        saw_done = 1'b1;
        done_cnt++;
      end
      if (rst_at > 0 && cap_n == rst_at) begin
        rst = 1'b1;
        return;
      end
      start    = (cyc == 0) || (restart && (cyc == 8 || saw_done));
      in_valid = (vmode == 0) ? 1'b1 : ((cyc % 2) == 0);
      in_rgb   = vec[(idx > 7) ? 7 : idx];
      if (in_ready) rdy_cycles++;
      if (in_valid && in_ready) begin
        idx++;
        xfers++;
      end
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string fr);
    int r, c, e;
    check({fr, "_count"}, cap_n, N);
    check({fr, "_done_cnt"}, done_cnt, 1);
    for (int i = 0; i < N && i < 64; i++) begin
      r = i / PW;
      c = i % PW;
      e = (r == 0 || r == H + 1 || c == 0 || c == PW - 1) ? 0 : exp_y[(r - 1) * W + (c - 1)];
      check($sformatf("%s_pix%0d", fr, i), int'(cap_d[i]), e);
      check($sformatf("%s_sof%0d", fr, i), int'(cap_sof[i]), (i == 0) ? 1 : 0);
      check($sformatf("%s_sol%0d", fr, i), int'(cap_sol[i]), (c == 0) ? 1 : 0);
      check($sformatf("%s_done%0d", fr, i), int'(cap_done[i]), (i == N - 1) ? 1 : 0);
    end
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    int hits;
    hits = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (busy || out_valid || done || in_ready) hits++;
    end
    check(tag, hits, 0);
  endtask

  bit ok;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_rgb = 24'd0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sol", int'(out_sol), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // White frame, source always valid.
    for (int i = 0; i < 8; i++) begin vec[i] = 24'hFFFFFF; exp_y[i] = 255; end
    run_frame(0, 0, 1'b0, ok);
    check("white_timeout", int'(ok), 1);
    check_frame("white");
    check("white_xfers", xfers, 8);
    check("white_bubbles", bubbles, 0);
    check("white_rdy_cycles", rdy_cycles, 8);
    check_idle("white_idle_after", 3);

    // Pure primaries cycled.
    vec[0] = 24'hFF0000; vec[1] = 24'h00FF00; vec[2] = 24'h0000FF; vec[3] = 24'hFF0000;
    vec[4] = 24'h00FF00; vec[5] = 24'h0000FF; vec[6] = 24'hFF0000; vec[7] = 24'h00FF00;
    exp_y[0] = 76;  exp_y[1] = 149; exp_y[2] = 28;  exp_y[3] = 76;
    exp_y[4] = 149; exp_y[5] = 28;  exp_y[6] = 76;  exp_y[7] = 149;
    run_frame(0, 0, 1'b0, ok);
    check("rgb_timeout", int'(ok), 1);
    check_frame("rgb");

    // Mixed colours with in_valid toggling: 3 + 4 bubbles in the two active rows.
    vec[0] = 24'h0A141E; vec[1] = 24'h804020; vec[2] = 24'hC86432; vec[3] = 24'h010101;
    vec[4] = 24'hFF0000; vec[5] = 24'h00FF00; vec[6] = 24'h0000FF; vec[7] = 24'hFFFFFF;
    exp_y[0] = 18;  exp_y[1] = 79;  exp_y[2] = 124; exp_y[3] = 1;
    exp_y[4] = 76;  exp_y[5] = 149; exp_y[6] = 28;  exp_y[7] = 255;
    run_frame(1, 0, 1'b0, ok);
    check("tog_timeout", int'(ok), 1);
    check_frame("tog");
    check("tog_xfers", xfers, 8);
    check("tog_bubbles", bubbles, 7);
    check("tog_rdy_cycles", rdy_cycles, 15);

    // Reset after the 10th output abandons the frame.
    for (int i = 0; i < 8; i++) begin vec[i] = 24'hFFFFFF; exp_y[i] = 255; end
    run_frame(0, 10, 1'b0, ok);
    check("abort_no_done", done_cnt, 0);
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_out_sof", int'(out_sof), 0);
    check("abort_out_sol", int'(out_sol), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    run_frame(0, 0, 1'b0, ok);
    check("after_abort_timeout", int'(ok), 1);
    check_frame("after_abort");

    // Start mid-frame and in the done cycle must both be ignored.
    run_frame(0, 0, 1'b1, ok);
    check("restart_timeout", int'(ok), 1);
    check_frame("restart");
    check_idle("restart_idle_after", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_pad.md
# gray_pad

Upstream pixel-conditioning stage of the edge-detection pipeline. Accepts an RGB raster over a valid/ready handshake, converts each pixel to 8-bit luma, and emits a zero-bordered grayscale stream (one zero row top and bottom, one zero column left and right) in raster order. The output width is IMG_W+2, which is the row pitch the Sobel stage's line buffer is sized for. One pixel per clock when the source keeps up.

## Interface
- IMG_W, 480, active pixels per row
- IMG_H, 480, active rows per frame
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
- in_rgb  in  24  {R[23:16], G[15:8], B[7:0]}
- in_valid  in  1  in_rgb holds a pixel
- in_ready  out  1  block accepts in_rgb this cycle
- out_data  out  8  padded luma pixel
- out_valid  out  1  out_data is a pixel of the padded frame
- out_sol  out  1  first pixel of a padded row (column 0)
- out_sof  out  1  first pixel of the padded frame
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, asserted with the final output pixel

## Operation
- Handshake: input transfer happens when in_valid and in_ready are both high. in_ready is combinational: high only in ACTIVE. The block never drops or duplicates an accepted pixel.
- Luma: Y = (77·R + 150·G + 29·B) >> 8. Use a 16-bit unsigned accumulator. The maximum sum is 65280, so there is no overflow and Y ≤ 255. Truncate; do not round.
- Counters:
  - col runs 0..IMG_W+1.
  - row runs 0..IMG_H+1.
  - Both clear on rst and on leaving IDLE.
- FSM states: IDLE, TOP, LEFT, ACTIVE, RIGHT, BOTTOM.
  - IDLE → TOP on start.
  - TOP emits IMG_W+2 zeros, then goes to LEFT with row=1.
  - LEFT emits one zero, then goes to ACTIVE.
  - ACTIVE emits one luma pixel per transfer. It holds while in_valid is low. After IMG_W transfers it goes to RIGHT.
  - RIGHT emits one zero. It goes to LEFT if row < IMG_H, otherwise to BOTTOM.
  - BOTTOM emits IMG_W+2 zeros, then goes to IDLE.
- A pad state emits exactly one pixel every cycle, regardless of in_valid.
- A padded frame is exactly (IMG_W+2)·(IMG_H+2) pixels.
- start arriving while busy is ignored.
- start arriving in the same cycle as done is ignored. A new frame needs start while in IDLE.
- rst mid-frame forces IDLE and clears counters. Partial output is abandoned and no done is generated.

## Timing
- All outputs are registered. Reset values:
  - out_data=0, out_valid=0, out_sol=0, out_sof=0, done=0.
  - busy=0 and in_ready=0, since they follow state=IDLE.
- Latency:
  - An accepted pixel or emitted pad at cycle t appears on out_data/out_valid at t+1.
  - The first output (out_sof) appears 2 cycles after the start pulse: start at t, TOP entered t+1, output t+2.
- Bubbles:
  - An ACTIVE cycle with no transfer gives out_valid=0 and out_data=0 on the next cycle.
  - There are no other bubbles.
- Flags:
  - out_sol is high with the pixel at col=0 of every padded row.
  - out_sof is high only with row=0, col=0.
  - done is high in the same cycle as the last BOTTOM pixel.
- busy is high from the cycle after start through the cycle in which the final BOTTOM pixel is emitted into the output register.

## Structure
- Shared package `img_pkg` holds:
  - IMG_W/IMG_H defaults and the derived PAD_W = IMG_W+2, the Sobel row pitch.
  - Luma coefficients 77/150/29.
  - The gray_pad state enum.
- The Sobel stage imports PAD_W from the same package.
- One sub-module, `rgb_luma`: combinational, 24-bit RGB in, 8-bit Y out. It is instantiated once; the output register lives in gray_pad.

## Test plan
- IMG_W=4, IMG_H=2, in_valid held high, in_rgb=FFFFFF → 24 valid outputs. Rows 0 and 3 all 0. Rows 1–2 are 0,255,255,255,255,0. out_sof on output 0. out_sol on outputs 0,6,12,18. done with output 23.
- Same frame with in_rgb=FF0000, 00FF00, 0000FF cycled → luma 76, 149, 28 in the active positions.
- in_valid toggling 1,0,1,0 during ACTIVE → in_ready high only in ACTIVE. Exactly 8 transfers. One out_valid=0 bubble per low cycle. Pixel order is preserved.
- rst asserted at the 10th output of a frame → next cycle all outputs 0, busy=0. A subsequent start produces a complete 24-pixel frame beginning with out_sof.
- start re-pulsed mid-frame and again in the done cycle → both ignored. Frame length stays 24 and the block stays IDLE afterward.
- Default parameters, random RGB → 482·482 outputs, and each active pixel equals the reference luma formula.
